// File: rtl/mips_sim_pkg.sv
// Shared constants for the simulation monitor.
//   EXIT_ADDR_DEF / CON_ADDR_DEF : default magic store addresses
//   state_t                      : monitor FSM encoding (RUN=0, HALTED=1, TIMEOUT=2)
package mips_sim_pkg;
  localparam logic [31:0] EXIT_ADDR_DEF = 32'hFFFF_FFF0;
  localparam logic [31:0] CON_ADDR_DEF  = 32'hFFFF_FFF4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;
endpackage

// File: rtl/mips_sim_monitor_if.sv
// Core store bus plus console byte stream seen by the monitor.
//   master : core/harness side (drives stores and con_ready)
//   slave  : monitor side (drives con_valid/con_data)
interface mips_sim_monitor_if;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (output mem_write_en, mem_addr, mem_wdata, con_ready,
                  input  con_valid, con_data);
  modport slave  (input  mem_write_en, mem_addr, mem_wdata, con_ready,
                  output con_valid, con_data);
endinterface

// File: rtl/mips_sim_monitor_fifo.sv
// mon_fifo: synchronous FIFO with a registered head output.
//   push/din      : write side; accepted when not full, or when full and popping
//   ready         : consumer pops the head when valid && ready
//   valid/dout    : head byte and its qualifier (no push->valid bypass)
//   full          : pointer-derived full flag
module mon_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr, rd, rd_n;
  logic [W-1:0] head_n;
  logic         pop, push_ok;

  // Extra wrap bit distinguishes full from empty when indices match.
  assign valid   = (wr != rd);
  assign full    = (wr[AW-1:0] == rd[AW-1:0]) && (wr[AW] != rd[AW]);
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign rd_n    = rd + (AW+1)'(pop);

  // Next head: the entry being written this edge if it lands at the new
  // read slot (FIFO effectively empty), otherwise the stored entry.
  always_comb begin
    head_n = mem[rd_n[AW-1:0]];
    if (push_ok && (wr == rd_n)) head_n = din;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr   <= '0;
      rd   <= '0;
      dout <= '0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      rd   <= rd_n;
      dout <= head_n;
    end
  end
endmodule

// File: rtl/mips_sim_monitor.sv
// mips_sim_monitor: passive harness endpoint on the core's store port.
//   clk, reset (async, active-low)
//   bus          : store bus in, console stream out
//   cycle_count  : RUN cycles, frozen after leaving RUN, saturating
//   halted/timeout/con_overflow : sticky status
//   exit_code    : word stored to EXIT_ADDR
module mips_sim_monitor
  import mips_sim_pkg::*;
#(
  parameter logic [31:0] EXIT_ADDR  = EXIT_ADDR_DEF,
  parameter logic [31:0] CON_ADDR   = CON_ADDR_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          WATCHDOG   = 1000,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  mips_sim_monitor_if.slave bus,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic             timeout,
  output logic [31:0]      exit_code,
  output logic             con_overflow
);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG - 1);

  state_t state, state_n;
  logic   exit_hit, con_hit, fifo_full, drop;

  assign exit_hit = bus.mem_write_en && (bus.mem_addr == EXIT_ADDR);
  assign con_hit  = bus.mem_write_en && (bus.mem_addr == CON_ADDR);
  // A pop in the same cycle frees a slot, so only a pop-less full push drops.
  assign drop     = con_hit && fifo_full && !(bus.con_valid && bus.con_ready);

  mon_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (con_hit),
    .din   (bus.mem_wdata[7:0]),
    .ready (bus.con_ready),
    .valid (bus.con_valid),
    .dout  (bus.con_data),
    .full  (fifo_full)
  );

  // Exit write takes priority over a coincident watchdog expiry.
  always_comb begin
    state_n = state;
    case (state)
      ST_RUN: begin
        if (exit_hit)                    state_n = ST_HALTED;
        else if (cycle_count == WD_LAST) state_n = ST_TIMEOUT;
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      cycle_count  <= '0;
      exit_code    <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      con_overflow <= 1'b0;
    end else begin
      state   <= state_n;
      halted  <= (state_n == ST_HALTED);
      timeout <= (state_n == ST_TIMEOUT);
      // The exit edge itself is not counted.
      if (state == ST_RUN && !exit_hit && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (state == ST_RUN && exit_hit) exit_code <= bus.mem_wdata;
      if (drop) con_overflow <= 1'b1;
    end
  end
endmodule
